// File: rtl/kamacore_fetch_ctrl.sv
// kamacore_fetch_ctrl: instruction-fetch sequencer.
// Owns the PC, presents it to instruction memory (asynchronous read) and registers
// the returned word into the IF/ID output slot behind a valid/ready handshake.
// Handles branch redirect/flush, halt/resume and counts accepted instructions.
//
// state | meaning
// RUN   | fetching: a new word is captured whenever the output slot is free
// HALT  | no new fetches; a live output word drains, pc moves only on a branch
module kamacore_fetch_ctrl #(
  parameter int ADDR_WIDTH  = 8,
  parameter int CPU_WIDTH   = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   branch_valid,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  input  logic                   halt_req,
  input  logic                   resume,
  input  logic                   id_ready,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [CPU_WIDTH-1:0]   imem_rdata,
  output logic                   if_valid,
  output logic [CPU_WIDTH-1:0]   if_instruction,
  output logic [ADDR_WIDTH-1:0]  if_pc,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] issue_count
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  xfer;
  logic                  slot_free;
  logic                  fetch_en;
  logic                  drop_valid;
  logic                  count_en;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_RUN;
    else     state_q <= state_d;
  end

  // Next state: halt_req wins over resume when both arrive while halted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (halt_req) state_d = S_HALT;
      S_HALT:  if (resume && !halt_req) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // Fetch/flush control: branch beats halt beats fetch; a flushed word is never counted.
  always_comb begin
    xfer       = if_valid && id_ready;
    slot_free  = !if_valid || id_ready;
    fetch_en   = !branch_valid && (state_q == S_RUN) && !halt_req && slot_free;
    drop_valid = branch_valid || (xfer && !fetch_en);
    count_en   = xfer && !branch_valid && (issue_count != CNT_MAX);
  end

  // Datapath registers: pc, output slot and saturating issue counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q           <= '0;
      if_valid       <= 1'b0;
      if_instruction <= '0;
      if_pc          <= '0;
      issue_count    <= '0;
    end else begin
      if (branch_valid)  pc_q <= branch_target;
      else if (fetch_en) pc_q <= pc_q + 1'b1;

      if (fetch_en) begin
        if_valid       <= 1'b1;
        if_instruction <= imem_rdata;
        if_pc          <= pc_q;
      end else if (drop_valid) begin
        if_valid <= 1'b0;
      end

      if (count_en) issue_count <= issue_count + 1'b1;
    end
  end

  assign imem_addr = pc_q;
  assign halted    = (state_q == S_HALT);

endmodule
